md5_match_detector: RTL and testbench

MD5_MATCH_DETECTOR -- requirements
Module: md5_match_detector

---
 rtl/md5_match_detector.sv | 125 ++++++++++++
 tb/tb_md5_match_detector.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/md5_match_detector.sv
// Watches the MD5 core output for a digest equal to a loaded target and captures
// the first matching message; counts every valid digest compared while armed.
module md5_match_detector #(
    parameter int LATENCY = 66,
    parameter int CNT_W   = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [127:0]       target,
    input  logic               in_valid,
    input  logic [127:0]       hash,
    input  logic [511:0]       message_out,
    output logic               armed,
    output logic               found,
    output logic [511:0]       match_message,
    output logic [127:0]       match_hash,
    output logic [CNT_W-1:0]   checked_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FOUND = 2'd2
    } state_t;

    state_t             state_r;
    logic [LATENCY-1:0] vpipe_r;
    logic [127:0]       target_r;
    logic               armed_r;
    logic               found_r;
    logic [511:0]       match_message_r;
    logic [127:0]       match_hash_r;
    logic [CNT_W-1:0]   count_r;

    logic               out_valid_s;
    logic               hit_s;

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign out_valid_s = vpipe_r[LATENCY-1];
    assign hit_s       = (hash == target_r);

    // Valid pipeline plus the IDLE/ARMED/FOUND controller; start outranks everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            vpipe_r         <= {LATENCY{1'b0}};
            target_r        <= 128'd0;
            armed_r         <= 1'b0;
            found_r         <= 1'b0;
            match_message_r <= 512'd0;
            match_hash_r    <= 128'd0;
            count_r         <= {CNT_W{1'b0}};
        end else begin
            vpipe_r[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end

            if (start) begin
                state_r         <= ARMED;
                armed_r         <= 1'b1;
                found_r         <= 1'b0;
                target_r        <= target;
                count_r         <= {CNT_W{1'b0}};
                match_message_r <= 512'd0;
                match_hash_r    <= 128'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ARMED: begin
                        if (stop) begin
                            state_r <= IDLE;
                            armed_r <= 1'b0;
                        end else if (out_valid_s) begin
                            count_r <= sat_inc(count_r);
                            if (hit_s) begin
                                state_r         <= FOUND;
                                armed_r         <= 1'b0;
                                found_r         <= 1'b1;
                                match_hash_r    <= hash;
                                match_message_r <= message_out;
                            end else begin
                                state_r <= ARMED;
                            end
                        end else begin
                            state_r <= ARMED;
                        end
                    end
                    FOUND: begin
                        if (stop) begin
                            state_r <= IDLE;
                            found_r <= 1'b0;
                        end else begin
                            state_r <= FOUND;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        armed_r <= 1'b0;
                        found_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign armed         = armed_r;
    assign found         = found_r;
    assign match_message = match_message_r;
    assign match_hash    = match_hash_r;
    assign checked_count = count_r;

endmodule

// File: tb/tb_md5_match_detector.sv
// Scoreboard bench: a behavioural delay line stands in for the MD5 core; expected
// captures are queued at stimulus time and checked when found rises.
module tb_md5_match_detector;

    localparam int L  = 66;
    localparam int CW = 4;

    // md5("") = d41d8cd98f00b204e9800998ecf8427e, as little-endian words {a,b,c,d}
    localparam logic [127:0] T0  = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] T1  = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [511:0] PAD = {8'h80, 504'd0};
    localparam logic [511:0] M1  = {480'd0, 32'hcafe_0011};
    localparam logic [511:0] M2  = {480'd0, 32'hcafe_0022};
    localparam logic [511:0] M3  = {480'd0, 32'hcafe_0033};

    logic          clk = 1'b0;
    logic          rst, start, stop, in_valid;
    logic [127:0]  target;
    logic [127:0]  cand_hash;
    logic [511:0]  cand_msg;
    logic [127:0]  hash;
    logic [511:0]  message_out;
    logic          armed, found;
    logic [511:0]  match_message;
    logic [127:0]  match_hash;
    logic [CW-1:0] checked_count;

    logic [127:0]  hpipe [L];
    logic [511:0]  mpipe [L];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    logic          found_q = 1'b0;

    typedef struct {
        logic [127:0]  h;
        logic [511:0]  m;
        logic [CW-1:0] cnt;
        int            at;
    } exp_t;
    exp_t sb_q[$];

    md5_match_detector #(.LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .target(target),
        .in_valid(in_valid), .hash(hash), .message_out(message_out),
        .armed(armed), .found(found), .match_message(match_message),
        .match_hash(match_hash), .checked_count(checked_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in hash core: candidate appears at the core output L cycles later
    always @(posedge clk) begin
        hpipe[0] <= cand_hash;
        mpipe[0] <= cand_msg;
        for (int i = 1; i < L; i++) begin
            hpipe[i] <= hpipe[i-1];
            mpipe[i] <= mpipe[i-1];
        end
    end
    assign hash        = hpipe[L-1];
    assign message_out = mpipe[L-1];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of found is matched against the next queued expectation
    always @(negedge clk) begin
        if (found && !found_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_found", 512'(found), 512'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_hash",  512'(match_hash), 512'(e.h));
                check("sb_msg",   match_message, e.m);
                check("sb_count", 512'(checked_count), 512'(e.cnt));
                check("sb_cycle", 512'(cyc), 512'(e.at));
            end
        end
        found_q <= found;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [127:0] t, input logic with_stop);
        start = 1'b1; stop = with_stop; target = t;
        tick();
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic feed(input logic [127:0] h, input logic [511:0] m);
        in_valid = 1'b1; cand_hash = h; cand_msg = m;
        tick();
        in_valid = 1'b0; cand_hash = 128'd0; cand_msg = 512'd0;
    endtask

    task automatic expect_match(input logic [127:0] h, input logic [511:0] m, input logic [CW-1:0] c);
        exp_t e;
        e.h = h; e.m = m; e.cnt = c; e.at = cyc + 1 + L;
        sb_q.push_back(e);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb_q.size() != 0; i++) tick();
        if (sb_q.size() != 0) begin
            check("found_timeout", 512'(sb_q.size()), 512'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        target = 128'd0; cand_hash = 128'd0; cand_msg = 512'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_armed", 512'(armed), 512'd0);
        check("rst_found", 512'(found), 512'd0);
        check("rst_count", 512'(checked_count), 512'd0);
        check("rst_mhash", 512'(match_hash), 512'd0);

        // Empty-message candidate against md5("")
        pulse_start(T0, 1'b0);
        check("arm_armed", 512'(armed), 512'd1);
        expect_match(T0, PAD, 4'd1);
        feed(T0, PAD);
        drain(L + 10);

        // Re-arm from FOUND, 10 misses, the hit, then 5 more with a late duplicate
        pulse_start(T0, 1'b0);
        check("rearm_found", 512'(found), 512'd0);
        check("rearm_armed", 512'(armed), 512'd1);
        check("rearm_count", 512'(checked_count), 512'd0);
        check("rearm_msg", match_message, 512'd0);
        for (int i = 0; i < 10; i++) feed(T0 ^ 128'(i + 1), M2);
        expect_match(T0, M1, 4'd11);
        feed(T0, M1);
        for (int i = 0; i < 5; i++) feed((i == 2) ? T0 : T1, M2);
        drain(L + 10);
        repeat (L) tick();
        check("hold_count", 512'(checked_count), 512'd11);
        check("hold_msg", match_message, M1);
        check("hold_found", 512'(found), 512'd1);

        // New target from FOUND: old digest must now miss
        pulse_start(T1, 1'b0);
        check("new_found", 512'(found), 512'd0);
        check("new_msg", match_message, 512'd0);
        feed(T0, M2);
        expect_match(T1, M3, 4'd2);
        feed(T1, M3);
        drain(L + 10);

        // Stop from FOUND keeps the capture
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_found", 512'(found), 512'd0);
        check("stop_mhash", 512'(match_hash), 512'(T1));

        // start+stop together: start wins
        pulse_start(T0, 1'b1);
        check("ss_armed", 512'(armed), 512'd1);
        check("ss_count", 512'(checked_count), 512'd0);
        feed(T1, M2);
        repeat (3) tick();
        begin
            int hit_edge;
            hit_edge = cyc + 1 + L;
            feed(T0, M1);
            while (cyc < hit_edge - 1) tick();
            stop = 1'b1; tick(); stop = 1'b0;
        end
        repeat (2) tick();
        check("stophit_armed", 512'(armed), 512'd0);
        check("stophit_found", 512'(found), 512'd0);
        check("stophit_count", 512'(checked_count), 512'd1);

        // Saturation of the 4-bit counter
        pulse_start(T1, 1'b0);
        for (int i = 0; i < 20; i++) feed(T0, M2);
        repeat (L + 5) tick();
        check("sat_count", 512'(checked_count), 512'd15);
        feed(T0, M2);
        repeat (L + 5) tick();
        check("sat_hold", 512'(checked_count), 512'd15);

        // Reset with 30 matching candidates in flight, then re-arm immediately
        pulse_start(T0, 1'b0);
        for (int i = 0; i < 30; i++) feed(T0, M3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_armed", 512'(armed), 512'd0);
        check("mrst_count", 512'(checked_count), 512'd0);
        pulse_start(T0, 1'b0);
        repeat (L + 10) tick();
        check("mrst_found", 512'(found), 512'd0);
        check("mrst_count2", 512'(checked_count), 512'd0);
        check("mrst_mhash", 512'(match_hash), 512'd0);
        check("mrst_msg", match_message, 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
